lines_stats_tracker: RTL and testbench

Accumulates per-player line statistics for the versus game. Consumes piece-lock events from the game logic, computes outgoing garbage (base attack + back-to-back + combo bonuses), and maintains the saturating `lines_cleared` and `lines_sent` totals that the lines pixel driver renders. Also emits a one-cycle garbage pulse toward the network/garbage-queue logic.

---
 rtl/lines_stats_tracker_pkg.sv | 58 +++++
 rtl/lines_stats_tracker_garbage_calc.sv | 41 ++++
 rtl/lines_stats_tracker.sv | 107 ++++++++++
 tb/tb_lines_stats_tracker.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/lines_stats_tracker_pkg.sv
// Shared types and scoring helpers for the per-player line statistics tracker.
// Attack tables, combo bonus ladder and the saturating total adder live here.
package lines_stats_tracker_pkg;

  localparam int STAT_MAX = 999;

  typedef logic [3:0] garbage_t;
  typedef logic [2:0] lines_t;

  typedef struct packed {
    logic     valid;
    lines_t   lines;
    garbage_t attack;
  } stage1_t;

  function automatic lines_t clamp_lines(input lines_t raw);
    return (raw > 3'd4) ? 3'd4 : raw;
  endfunction

  function automatic garbage_t base_attack_normal(input lines_t lines);
    case (lines)
      3'd2:    return 4'd1;
      3'd3:    return 4'd2;
      3'd4:    return 4'd4;
      default: return 4'd0;
    endcase
  endfunction

  // A four-row clear is scored as a plain tetris whether or not a T-spin was flagged.
  function automatic garbage_t base_attack_tspin(input lines_t lines);
    case (lines)
      3'd1:    return 4'd2;
      3'd2:    return 4'd4;
      3'd3:    return 4'd6;
      3'd4:    return 4'd4;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [2:0] combo_bonus(input int unsigned combo);
    if (combo >= 11)      return 3'd5;
    else if (combo >= 8)  return 3'd4;
    else if (combo >= 6)  return 3'd3;
    else if (combo >= 4)  return 3'd2;
    else if (combo >= 2)  return 3'd1;
    else                  return 3'd0;
  endfunction

  // Sum at 11 bits so the carry out of a 10-bit total is never lost before clamping.
  function automatic logic [9:0] sat_add(input logic [9:0]  total,
                                         input logic [3:0]  inc,
                                         input logic [10:0] max_val);
    logic [10:0] sum;
    sum = {1'b0, total} + {7'b0, inc};
    return (sum > max_val) ? max_val[9:0] : sum[9:0];
  endfunction

endpackage

// File: rtl/lines_stats_tracker_garbage_calc.sv
// Combinational attack calculator for a single lock: base table, back-to-back
// bonus and combo bonus, plus the back-to-back flag the lock leaves behind.
module garbage_calc
  import lines_stats_tracker_pkg::*;
#(
  parameter int COMBO_W = 5
) (
  input  logic [2:0]         i_lines,
  input  logic               i_tspin,
  input  logic               i_b2b,
  input  logic [COMBO_W-1:0] i_combo,
  output logic [3:0]         o_attack,
  output logic               o_difficult,
  output logic               o_b2b_next
);

  garbage_t   w_base;
  logic       w_b2b_bonus;
  logic [2:0] w_combo_bonus;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    o_difficult   = 1'b0;
    w_base        = '0;
    w_b2b_bonus   = 1'b0;
    w_combo_bonus = '0;
    o_b2b_next    = i_b2b;

    o_difficult = (i_lines == 3'd4) || (i_tspin && (i_lines != 3'd0));
    w_base      = i_tspin ? base_attack_tspin(i_lines) : base_attack_normal(i_lines);
    w_b2b_bonus = o_difficult && i_b2b;

    if (i_lines != 3'd0) begin
      w_combo_bonus = combo_bonus(32'(i_combo));
      o_b2b_next    = o_difficult;
    end
  end

  assign o_attack = w_base + {3'b000, w_b2b_bonus} + {1'b0, w_combo_bonus};

endmodule

// File: rtl/lines_stats_tracker.sv
// Per-player line statistics: two-stage pipeline from piece-lock events to
// garbage pulses and saturating lines-cleared / lines-sent totals.
module lines_stats_tracker #(
  parameter int STAT_MAX = lines_stats_tracker_pkg::STAT_MAX,
  parameter int COMBO_W  = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_stats,
  input  logic               lock_valid,
  input  logic [2:0]         lock_lines,
  input  logic               lock_tspin,
  output logic [9:0]         lines_cleared,
  output logic [9:0]         lines_sent,
  output logic               garbage_valid,
  output logic [3:0]         garbage_count,
  output logic [COMBO_W-1:0] combo_count,
  output logic               b2b_active
);

  import lines_stats_tracker_pkg::*;

  logic               w_flush;
  lines_t             w_lines;
  logic [COMBO_W-1:0] w_combo_next;
  garbage_t           w_attack;
  logic               w_difficult;
  logic               w_b2b_next;

  stage1_t            r_s1;
  logic               r_in_combo;
  logic [COMBO_W-1:0] r_combo_count;
  logic               r_b2b;

  logic [9:0]         r_lines_cleared;
  logic [9:0]         r_lines_sent;
  logic               r_garbage_valid;
  garbage_t           r_garbage_count;

  assign w_flush = rst | clear_stats;

  // Post-update combo value; the bonus is scored on this, not on the prior count.
  always_comb begin
    w_lines      = clamp_lines(lock_lines);
    w_combo_next = '0;
    if (w_lines != 3'd0 && r_in_combo) begin
      w_combo_next = (&r_combo_count) ? r_combo_count : r_combo_count + COMBO_W'(1);
    end
  end

  garbage_calc #(
    .COMBO_W (COMBO_W)
  ) u_garbage_calc (
    .i_lines     (w_lines),
    .i_tspin     (lock_tspin),
    .i_b2b       (r_b2b),
    .i_combo     (w_combo_next),
    .o_attack    (w_attack),
    .o_difficult (w_difficult),
    .o_b2b_next  (w_b2b_next)
  );

  // Stage 1: combo / back-to-back state and the attack for this lock.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_s1          <= '0;
      r_in_combo    <= 1'b0;
      r_combo_count <= '0;
      r_b2b         <= 1'b0;
    end else begin
      r_s1.valid <= lock_valid;
      if (lock_valid) begin
        r_s1.lines    <= w_lines;
        r_s1.attack   <= w_attack;
        r_in_combo    <= (w_lines != 3'd0);
        r_combo_count <= w_combo_next;
        r_b2b         <= w_b2b_next | w_difficult;
      end
    end
  end

  // Stage 2: publish the garbage pulse and accumulate the saturating totals.
  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_lines_cleared <= '0;
      r_lines_sent    <= '0;
      r_garbage_valid <= 1'b0;
      r_garbage_count <= '0;
    end else begin
      r_garbage_valid <= r_s1.valid;
      if (r_s1.valid) begin
        r_garbage_count <= r_s1.attack;
        r_lines_cleared <= sat_add(r_lines_cleared, {1'b0, r_s1.lines}, 11'(STAT_MAX));
        r_lines_sent    <= sat_add(r_lines_sent, r_s1.attack, 11'(STAT_MAX));
      end
    end
  end

  assign lines_cleared = r_lines_cleared;
  assign lines_sent    = r_lines_sent;
  assign garbage_valid = r_garbage_valid;
  assign garbage_count = r_garbage_count;
  assign combo_count   = r_combo_count;
  assign b2b_active    = r_b2b;

endmodule

// File: tb/tb_lines_stats_tracker.sv
// Directed bench for lines_stats_tracker: inputs driven and outputs sampled on
// the falling edge; expected values are hand-computed from the scoring rules.
module tb_lines_stats_tracker;

  logic       clk;
  logic       rst;
  logic       clear_stats;
  logic       lock_valid;
  logic [2:0] lock_lines;
  logic       lock_tspin;
  logic [9:0] lines_cleared;
  logic [9:0] lines_sent;
  logic       garbage_valid;
  logic [3:0] garbage_count;
  logic [4:0] combo_count;
  logic       b2b_active;

  int n_checks = 0;
  int n_errors = 0;

  lines_stats_tracker #(
    .STAT_MAX (999),
    .COMBO_W  (5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .clear_stats   (clear_stats),
    .lock_valid    (lock_valid),
    .lock_lines    (lock_lines),
    .lock_tspin    (lock_tspin),
    .lines_cleared (lines_cleared),
    .lines_sent    (lines_sent),
    .garbage_valid (garbage_valid),
    .garbage_count (garbage_count),
    .combo_count   (combo_count),
    .b2b_active    (b2b_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle's inputs at the falling edge; outputs read right after reflect the previous rising edge.
  task automatic step(input logic v, input logic [2:0] l, input logic t, input logic clr);
    @(negedge clk);
    lock_valid  = v;
    lock_lines  = l;
    lock_tspin  = t;
    clear_stats = clr;
  endtask

  task automatic idle();
    step(1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst         = 1'b1;
    clear_stats = 1'b0;
    lock_valid  = 1'b0;
    lock_lines  = 3'd0;
    lock_tspin  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_lines_cleared", 32'(lines_cleared), 32'd0);
    check("rst_lines_sent",    32'(lines_sent),    32'd0);
    check("rst_garbage_valid", 32'(garbage_valid), 32'd0);
    check("rst_garbage_count", 32'(garbage_count), 32'd0);
    check("rst_combo_count",   32'(combo_count),   32'd0);
    check("rst_b2b",           32'(b2b_active),    32'd0);

    // Single tetris.
    step(1'b1, 3'd4, 1'b0, 1'b0);
    idle();
    check("t1_edge1_b2b",   32'(b2b_active),    32'd1);
    check("t1_edge1_gv",    32'(garbage_valid), 32'd0);
    idle();
    check("t1_gv",          32'(garbage_valid), 32'd1);
    check("t1_gc",          32'(garbage_count), 32'd4);
    check("t1_cleared",     32'(lines_cleared), 32'd4);
    check("t1_sent",        32'(lines_sent),    32'd4);
    check("t1_b2b",         32'(b2b_active),    32'd1);
    idle();
    check("t1_gv_one_shot", 32'(garbage_valid), 32'd0);

    // Back-to-back tetrises on consecutive cycles.
    step(1'b0, 3'd0, 1'b0, 1'b1);
    step(1'b1, 3'd4, 1'b0, 1'b0);
    check("clr_cleared", 32'(lines_cleared), 32'd0);
    check("clr_b2b",     32'(b2b_active),    32'd0);
    step(1'b1, 3'd4, 1'b0, 1'b0);
    idle();
    check("t2_first_gc",  32'(garbage_count), 32'd4);
    idle();
    check("t2_second_gv", 32'(garbage_valid), 32'd1);
    check("t2_second_gc", 32'(garbage_count), 32'd5);
    check("t2_sent",      32'(lines_sent),    32'd9);
    check("t2_cleared",   32'(lines_cleared), 32'd8);
    check("t2_combo",     32'(combo_count),   32'd1);

    // T-spin double, double, T-spin triple, then an empty lock.
    step(1'b0, 3'd0, 1'b0, 1'b1);
    step(1'b1, 3'd2, 1'b1, 1'b0);
    step(1'b1, 3'd2, 1'b0, 1'b0);
    step(1'b1, 3'd3, 1'b1, 1'b0);
    check("t3_tsd_gc",     32'(garbage_count), 32'd4);
    step(1'b1, 3'd0, 1'b0, 1'b0);
    check("t3_double_gc",  32'(garbage_count), 32'd1);
    check("t3_combo2",     32'(combo_count),   32'd2);
    idle();
    check("t3_tst_gc",     32'(garbage_count), 32'd7);
    check("t3_combo_drop", 32'(combo_count),   32'd0);
    check("t3_sent",       32'(lines_sent),    32'd12);
    check("t3_cleared",    32'(lines_cleared), 32'd7);
    idle();
    check("t3_zero_gv",    32'(garbage_valid), 32'd1);
    check("t3_zero_gc",    32'(garbage_count), 32'd0);
    check("t3_b2b_held",   32'(b2b_active),    32'd1);
    idle();
    check("t3_zero_gv_off", 32'(garbage_valid), 32'd0);

    // Twelve consecutive doubles climb the combo ladder.
    step(1'b0, 3'd0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b1, 3'd2, 1'b0, 1'b0);
    idle();
    check("t4_combo11",  32'(combo_count),   32'd11);
    check("t4_11th_gc",  32'(garbage_count), 32'd5);
    idle();
    check("t4_12th_gc",  32'(garbage_count), 32'd6);
    check("t4_sent",     32'(lines_sent),    32'd41);
    check("t4_cleared",  32'(lines_cleared), 32'd24);

    // Saturation: 249 tetrises + a double reach 998, one more tetris clamps to 999.
    step(1'b0, 3'd0, 1'b0, 1'b1);
    for (int i = 0; i < 249; i++) step(1'b1, 3'd4, 1'b0, 1'b0);
    step(1'b1, 3'd2, 1'b0, 1'b0);
    step(1'b1, 3'd4, 1'b0, 1'b0);
    idle();
    check("t5_cleared_998", 32'(lines_cleared), 32'd998);
    idle();
    check("t5_cleared_999", 32'(lines_cleared), 32'd999);
    check("t5_sent_999",    32'(lines_sent),    32'd999);
    check("t5_combo_sat",   32'(combo_count),   32'd31);
    step(1'b1, 3'd7, 1'b0, 1'b0);
    idle();
    idle();
    check("t5_clamped_gc",  32'(garbage_count), 32'd10);
    check("t5_cleared_hold", 32'(lines_cleared), 32'd999);
    check("t5_sent_hold",   32'(lines_sent),    32'd999);

    // Out-of-range line count is scored as four rows.
    step(1'b0, 3'd0, 1'b0, 1'b1);
    step(1'b1, 3'd6, 1'b0, 1'b0);
    idle();
    idle();
    check("t6_gc",      32'(garbage_count), 32'd4);
    check("t6_cleared", 32'(lines_cleared), 32'd4);

    // clear_stats one cycle after a lock discards it in flight.
    step(1'b1, 3'd4, 1'b0, 1'b0);
    step(1'b0, 3'd0, 1'b0, 1'b1);
    idle();
    check("t7_gv",      32'(garbage_valid), 32'd0);
    check("t7_gc",      32'(garbage_count), 32'd0);
    check("t7_cleared", 32'(lines_cleared), 32'd0);
    check("t7_sent",    32'(lines_sent),    32'd0);
    check("t7_b2b",     32'(b2b_active),    32'd0);
    check("t7_combo",   32'(combo_count),   32'd0);
    idle();
    check("t7_gv_late", 32'(garbage_valid), 32'd0);

    // A lock coinciding with clear_stats is dropped.
    step(1'b1, 3'd4, 1'b0, 1'b1);
    idle();
    idle();
    check("t8_gv",      32'(garbage_valid), 32'd0);
    check("t8_cleared", 32'(lines_cleared), 32'd0);
    check("t8_b2b",     32'(b2b_active),    32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
